// File: rtl/video_capture.sv
// Single-line video capture: samples a parallel RGB444 video stream, measures active
// line/frame size and stores one selected active line in an on-chip line buffer.
module video_capture #(
    parameter logic VSYNC_ACTIVE = 1'b0,
    parameter int   LINE_PIXELS  = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  vid_r,
    input  logic [3:0]  vid_g,
    input  logic [3:0]  vid_b,
    input  logic        vid_de,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic        cap_start,
    input  logic        cap_abort,
    input  logic [8:0]  cap_line,
    output logic        cap_busy,
    output logic        cap_done,
    output logic        cap_err,
    output logic        cap_ovf,
    output logic        irq_done,
    output logic [9:0]  meas_hactive,
    output logic [9:0]  meas_vactive,
    input  logic [9:0]  rd_addr,
    output logic [11:0] rd_data
);

    localparam int          AW            = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam logic [10:0] LINE_PIXELS_W = 11'(LINE_PIXELS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_WAIT_LINE  = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t      state_r, state_next_s;
    logic [3:0]  q_red_r, q_grn_r, q_blu_r;
    logic        q_de_r, q_hsync_r, q_vsync_r, q2_de_r, q2_vsync_r;
    logic [9:0]  pix_cnt_r, line_cnt_r, meas_h_r, meas_v_r;
    logic        h_arm_r, v_arm_r;
    logic [8:0]  target_r;
    logic        cap_busy_r, cap_done_r, cap_err_r, cap_ovf_r, irq_done_r;
    logic [11:0] mem_r [0:LINE_PIXELS-1];
    logic [11:0] rd_data_r;
    logic        frame_start_s, line_end_s, de_rise_s, line_hit_s, pix_in_range_s;
    logic        accept_s, set_err_s, set_done_s, capturing_s, wr_en_s, set_ovf_s;

    // Input sampling pipeline; pure data path, so it keeps tracking the stream through reset.
    always_ff @(posedge clk) begin
        q_red_r    <= vid_r;
        q_grn_r    <= vid_g;
        q_blu_r    <= vid_b;
        q_de_r     <= vid_de;
        q_hsync_r  <= vid_hsync;
        q_vsync_r  <= vid_vsync;
        q2_de_r    <= q_de_r;
        q2_vsync_r <= q_vsync_r;
    end

    assign frame_start_s  = (q_vsync_r == VSYNC_ACTIVE) && (q2_vsync_r != VSYNC_ACTIVE);
    assign line_end_s     = q2_de_r && !q_de_r;
    assign de_rise_s      = q_de_r && !q2_de_r;
    assign line_hit_s     = (line_cnt_r == {1'b0, target_r});
    assign pix_in_range_s = ({1'b0, pix_cnt_r} < LINE_PIXELS_W);

    // Pixel/line counters and measurements; the arm flags hold back partial line/frame results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_cnt_r  <= 10'd0;
            line_cnt_r <= 10'd0;
            meas_h_r   <= 10'd0;
            meas_v_r   <= 10'd0;
            h_arm_r    <= 1'b0;
            v_arm_r    <= 1'b0;
        end else begin
            if (line_end_s) begin
                pix_cnt_r <= 10'd0;
                if (h_arm_r) begin
                    meas_h_r <= pix_cnt_r;
                end
            end else if (q_de_r && (pix_cnt_r != 10'd1023)) begin
                pix_cnt_r <= pix_cnt_r + 10'd1;
            end
            if (!q2_de_r) begin
                h_arm_r <= 1'b1;
            end
            if (frame_start_s) begin
                line_cnt_r <= 10'd0;
                v_arm_r    <= 1'b1;
                if (v_arm_r) begin
                    meas_v_r <= line_cnt_r;
                end
            end else if (line_end_s && (line_cnt_r != 10'd1023)) begin
                line_cnt_r <= line_cnt_r + 10'd1;
            end
        end
    end

    // Capture FSM next-state and strobe decode; abort overrides everything else.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        set_err_s    = 1'b0;
        set_done_s   = 1'b0;
        capturing_s  = 1'b0;
        if (cap_abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cap_start) begin
                        state_next_s = ST_WAIT_FRAME;
                        accept_s     = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start_s) begin
                        state_next_s = ST_WAIT_LINE;
                    end else begin
                        state_next_s = ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_LINE: begin
                    if (frame_start_s) begin
                        state_next_s = ST_IDLE;
                        set_err_s    = 1'b1;
                    end else if (de_rise_s && line_hit_s) begin
                        // the rising-edge pixel is pixel 0 and must be stored too
                        state_next_s = ST_CAPTURE;
                        capturing_s  = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT_LINE;
                    end
                end
                ST_CAPTURE: begin
                    capturing_s = 1'b1;
                    if (line_end_s || frame_start_s) begin
                        state_next_s = ST_DONE;
                        set_done_s   = 1'b1;
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en_s   = capturing_s && q_de_r && pix_in_range_s;
    assign set_ovf_s = capturing_s && q_de_r && !pix_in_range_s;

    // FSM state, status flags and interrupt pulse, all registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cap_busy_r <= 1'b0;
            cap_done_r <= 1'b0;
            cap_err_r  <= 1'b0;
            cap_ovf_r  <= 1'b0;
            irq_done_r <= 1'b0;
            target_r   <= 9'd0;
        end else begin
            state_r    <= state_next_s;
            cap_busy_r <= (state_next_s != ST_IDLE);
            irq_done_r <= set_done_s | set_err_s;
            if (accept_s) begin
                target_r   <= cap_line;
                cap_done_r <= 1'b0;
                cap_err_r  <= 1'b0;
                cap_ovf_r  <= 1'b0;
            end else begin
                if (set_done_s) cap_done_r <= 1'b1;
                if (set_err_s)  cap_err_r  <= 1'b1;
                if (set_ovf_s)  cap_ovf_r  <= 1'b1;
            end
        end
    end

    // Line buffer: one write port, one registered read port returning pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[pix_cnt_r[AW-1:0]] <= {q_red_r, q_grn_r, q_blu_r};
        end
        if ({1'b0, rd_addr} < LINE_PIXELS_W) begin
            rd_data_r <= mem_r[rd_addr[AW-1:0]];
        end else begin
            rd_data_r <= 12'h000;
        end
    end

    assign cap_busy     = cap_busy_r;
    assign cap_done     = cap_done_r;
    assign cap_err      = cap_err_r;
    assign cap_ovf      = cap_ovf_r;
    assign irq_done     = irq_done_r;
    assign meas_hactive = meas_h_r;
    assign meas_vactive = meas_v_r;
    assign rd_data      = rd_data_r;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: a small timing generator with per-frame geometry,
// table-driven line-buffer readback and hand-written multi-cycle sequences.
module tb_video_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  vid_r, vid_g, vid_b;
    logic        vid_de, vid_hsync, vid_vsync;
    logic        cap_start, cap_abort;
    logic [8:0]  cap_line;
    logic        cap_busy, cap_done, cap_err, cap_ovf, irq_done;
    logic [9:0]  meas_hactive, meas_vactive;
    logic [9:0]  rd_addr;
    logic [11:0] rd_data;

    int total = 0;
    int bad = 0;
    int irq_cnt = 0;
    int frame_no = 0;
    int gen_line = -1;
    int gen_x = 0;
    int cfg_h = 48;
    int cfg_hlast = 48;
    int cfg_v = 120;

    typedef struct {
        string       name;
        logic [9:0]  addr;
        logic [11:0] exp;
    } rd_vec_t;

    video_capture dut (
        .clk(clk), .reset_n(reset_n),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_de(vid_de), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .cap_start(cap_start), .cap_abort(cap_abort), .cap_line(cap_line),
        .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err), .cap_ovf(cap_ovf),
        .irq_done(irq_done), .meas_hactive(meas_hactive), .meas_vactive(meas_vactive),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (irq_done === 1'b1) irq_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic rd_chk(input rd_vec_t v);
        rd_addr = v.addr;
        @(negedge clk);
        chk(v.name, 32'(rd_data), 32'(v.exp));
    endtask

    task automatic pulse_start(input logic [8:0] line);
        cap_line  = line;
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
    endtask

    // Video timing generator: vsync (active low), porch, then cfg_v lines with blanking.
    initial begin
        int h, hl, v, w;
        vid_r = 4'h0; vid_g = 4'h0; vid_b = 4'h0;
        vid_de = 1'b0; vid_hsync = 1'b0; vid_vsync = 1'b1;
        forever begin
            h = cfg_h; hl = cfg_hlast; v = cfg_v;
            @(negedge clk);
            vid_vsync = 1'b0;
            frame_no++;
            repeat (16) @(negedge clk);
            vid_vsync = 1'b1;
            repeat (16) @(negedge clk);
            for (int y = 0; y < v; y++) begin
                gen_line = y;
                w = (y == v - 1) ? hl : h;
                for (int x = 0; x < w; x++) begin
                    gen_x  = x;
                    vid_de = 1'b1;
                    vid_r  = 4'(x);
                    vid_g  = 4'(y);
                    vid_b  = 4'h5;
                    @(negedge clk);
                end
                vid_de = 1'b0; vid_r = 4'h0; vid_g = 4'h0; vid_b = 4'h0;
                vid_hsync = 1'b1;
                repeat (4) @(negedge clk);
                vid_hsync = 1'b0;
                repeat (4) @(negedge clk);
            end
            gen_line = -1;
            repeat (16) @(negedge clk);
        end
    end

    initial begin
        rd_vec_t rd_a[3];
        rd_vec_t rd_b[5];
        int fs, irq_base;

        rd_a[0] = '{"A_rd37",  10'd37,  12'h545};
        rd_a[1] = '{"A_rd0",   10'd0,   12'h045};
        rd_a[2] = '{"A_rd47",  10'd47,  12'hF45};
        rd_b[0] = '{"D_rd0",   10'd0,   12'h005};
        rd_b[1] = '{"D_rd37",  10'd37,  12'h505};
        rd_b[2] = '{"D_rd639", 10'd639, 12'hF05};
        rd_b[3] = '{"D_rd640", 10'd640, 12'h000};
        rd_b[4] = '{"D_rd700", 10'd700, 12'h000};

        reset_n = 1'b0; cap_start = 1'b0; cap_abort = 1'b0; cap_line = 9'd0; rd_addr = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(cap_busy), 32'd0);
        chk("rst_done", 32'(cap_done), 32'd0);
        chk("rst_err",  32'(cap_err),  32'd0);
        chk("rst_ovf",  32'(cap_ovf),  32'd0);
        chk("rst_irq",  32'(irq_done), 32'd0);
        chk("rst_mh",   32'(meas_hactive), 32'd0);
        chk("rst_mv",   32'(meas_vactive), 32'd0);
        reset_n = 1'b1;

        // A: capture line 100 of the frame after the arm; partial frame must be skipped
        for (int i = 0; i < 20000 && !(frame_no == 1 && gen_line == 10); i++) @(negedge clk);
        chk("A_reach", 32'(frame_no == 1 && gen_line == 10), 32'd1);
        irq_base = irq_cnt; fs = frame_no;
        pulse_start(9'd100);
        chk("A_busy", 32'(cap_busy), 32'd1);
        for (int i = 0; i < 20000 && !(cap_done || cap_err); i++) @(negedge clk);
        chk("A_done",  32'(cap_done), 32'd1);
        chk("A_err",   32'(cap_err),  32'd0);
        chk("A_ovf",   32'(cap_ovf),  32'd0);
        chk("A_irq",   32'(irq_done), 32'd1);
        chk("A_frame", 32'(frame_no), 32'(fs + 1));
        @(negedge clk);
        chk("A_idle", 32'(cap_busy), 32'd0);
        chk("A_irq1", 32'(irq_done), 32'd0);
        repeat (3) @(negedge clk);
        chk("A_irqcnt", 32'(irq_cnt - irq_base), 32'd1);
        for (int i = 0; i < 3; i++) rd_chk(rd_a[i]);

        // B: two full 480-line frames whose last line is 640 pixels wide
        fs = frame_no;
        cfg_h = 8; cfg_hlast = 640; cfg_v = 480;
        for (int i = 0; i < 30000 && frame_no < fs + 2; i++) @(negedge clk);
        cfg_h = 16; cfg_hlast = 16; cfg_v = 120;
        for (int i = 0; i < 30000 && frame_no < fs + 3; i++) @(negedge clk);
        chk("B_reach", 32'(frame_no), 32'(fs + 3));
        repeat (10) @(negedge clk);
        chk("B_mv", 32'(meas_vactive), 32'd480);
        chk("B_mh", 32'(meas_hactive), 32'd640);

        // C: target beyond the frame height -> error at the following frame start
        irq_base = irq_cnt; fs = frame_no;
        pulse_start(9'd500);
        for (int i = 0; i < 20000 && !(cap_done || cap_err); i++) @(negedge clk);
        chk("C_err",   32'(cap_err),  32'd1);
        chk("C_done",  32'(cap_done), 32'd0);
        chk("C_irq",   32'(irq_done), 32'd1);
        chk("C_frame", 32'(frame_no), 32'(fs + 2));
        repeat (3) @(negedge clk);
        chk("C_irqcnt", 32'(irq_cnt - irq_base), 32'd1);
        chk("C_idle",   32'(cap_busy), 32'd0);

        // D: 700-pixel lines overflow the 640-entry buffer
        cfg_h = 700; cfg_hlast = 700; cfg_v = 3;
        irq_base = irq_cnt; fs = frame_no;
        pulse_start(9'd0);
        for (int i = 0; i < 20000 && !(cap_done || cap_err); i++) @(negedge clk);
        cfg_h = 16; cfg_hlast = 16; cfg_v = 120;
        chk("D_done", 32'(cap_done), 32'd1);
        chk("D_ovf",  32'(cap_ovf),  32'd1);
        chk("D_err",  32'(cap_err),  32'd0);
        chk("D_mh",   32'(meas_hactive), 32'd700);
        chk("D_frame", 32'(frame_no), 32'(fs + 1));
        repeat (3) @(negedge clk);
        chk("D_irqcnt", 32'(irq_cnt - irq_base), 32'd1);
        for (int i = 0; i < 5; i++) rd_chk(rd_b[i]);

        // E: abort and start together in WAIT_LINE, then a start one cycle later
        irq_base = irq_cnt;
        pulse_start(9'd110);
        fs = frame_no;
        for (int i = 0; i < 10000 && frame_no < fs + 1; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("E_waitline", 32'(cap_busy), 32'd1);
        cap_start = 1'b1; cap_abort = 1'b1;
        @(negedge clk);
        cap_abort = 1'b0; cap_line = 9'd5;
        chk("E_abort_busy", 32'(cap_busy), 32'd0);
        chk("E_abort_done", 32'(cap_done), 32'd0);
        chk("E_abort_err",  32'(cap_err),  32'd0);
        chk("E_abort_ovf",  32'(cap_ovf),  32'd0);
        @(negedge clk);
        cap_start = 1'b0;
        chk("E_restart", 32'(cap_busy), 32'd1);
        cap_abort = 1'b1;
        @(negedge clk);
        cap_abort = 1'b0;
        chk("E_abort2", 32'(cap_busy), 32'd0);
        chk("E_irqcnt", 32'(irq_cnt - irq_base), 32'd0);

        // F: reset pulse in the middle of a capture, then measurement re-arming
        irq_base = irq_cnt;
        pulse_start(9'd2);
        fs = frame_no;
        for (int i = 0; i < 10000 && !(frame_no == fs + 1 && gen_line == 2 && gen_x == 10); i++)
            @(negedge clk);
        chk("F_reach", 32'(frame_no == fs + 1 && gen_line == 2 && gen_x == 10), 32'd1);
        chk("F_busy", 32'(cap_busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("F_rst_busy", 32'(cap_busy), 32'd0);
        chk("F_rst_mh",   32'(meas_hactive), 32'd0);
        chk("F_rst_mv",   32'(meas_vactive), 32'd0);
        chk("F_rst_irq",  32'(irq_done), 32'd0);
        for (int i = 0; i < 200 && !(gen_line == 3 && gen_x == 2); i++) @(negedge clk);
        chk("F_partial_mh", 32'(meas_hactive), 32'd0);
        for (int i = 0; i < 200 && !(gen_line == 4 && gen_x == 2); i++) @(negedge clk);
        chk("F_full_mh", 32'(meas_hactive), 32'd16);
        chk("F_done",    32'(cap_done), 32'd0);
        chk("F_irqcnt",  32'(irq_cnt - irq_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
